// File: rtl/conv2d_pkg.sv
// Shared widths, FSM state type and default kernel for the conv2d engine.
package conv2d_pkg;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 17;
    localparam int COEF_W = 4;
    localparam int ACC_W  = DATA_W + COEF_W + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Nine 4-bit weights packed with W0 (top-left) in the least significant nibble.
    localparam logic [9*COEF_W-1:0] KERNEL_DEF = {4'd1, 4'd2, 4'd1,
                                                  4'd2, 4'd4, 4'd2,
                                                  4'd1, 4'd2, 4'd1};
endpackage

// File: rtl/conv2d_if.sv
// Image-read / result-write bus between conv2d, its source memory and its sink.
interface conv2d_if;
    import conv2d_pkg::*;

    logic              start;
    logic [DATA_W-1:0] d_in;
    logic [ADDR_W-1:0] addr_rd;
    logic [ADDR_W-1:0] addr_wr;
    logic [DATA_W-1:0] d_out;
    logic              ready;

    modport master (output start, d_in, input addr_rd, addr_wr, d_out, ready);
    modport slave  (input start, d_in, output addr_rd, addr_wr, d_out, ready);
endinterface

// File: rtl/conv2d_mac.sv
// Weight select and multiply-accumulate over the nine taps of one output pixel;
// o_result is the shifted, saturated sum including the tap presented this cycle.
module conv2d_mac
    import conv2d_pkg::*;
#(
    parameter logic [9*COEF_W-1:0] WEIGHTS = KERNEL_DEF,
    parameter int                  SHIFT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [3:0]        i_tap,
    input  logic [DATA_W-1:0] i_pix,
    output logic [DATA_W-1:0] o_result
);
    localparam logic [ACC_W-1:0] MAX_PIX = ACC_W'({DATA_W{1'b1}});

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_sum;
    logic [COEF_W-1:0] w_coef;

    function automatic logic [DATA_W-1:0] shift_sat(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] s;
        s = v >> SHIFT;
        return (s > MAX_PIX) ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    always_comb begin
        w_coef = '0;
        for (int k = 0; k < 9; k++)
            if (i_tap == 4'(k)) w_coef = WEIGHTS[k*COEF_W +: COEF_W];
        w_sum    = r_acc + ACC_W'(w_coef) * ACC_W'(i_pix);
        o_result = shift_sat(w_sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= w_sum;
    end
endmodule

// File: rtl/conv2d.sv
// 3x3 valid-mode convolution engine: FSM walks each output pixel's nine taps
// through a combinational-read image port, then strobes the result out.
module conv2d
    import conv2d_pkg::*;
#(
    parameter int                  IMG_W   = 5,
    parameter int                  IMG_H   = 5,
    parameter logic [9*COEF_W-1:0] WEIGHTS = KERNEL_DEF,
    parameter int                  SHIFT   = 4
) (
    input  logic     clk,
    input  logic     rst,
    conv2d_if.slave  bus
);
    state_t            r_state, w_next;
    logic [3:0]        r_tap;
    logic [1:0]        r_kx;
    logic [ADDR_W-1:0] r_ox, r_oy, r_base;
    logic [ADDR_W-1:0] r_addr_rd, r_addr_wr;
    logic [DATA_W-1:0] r_dout, w_result;
    logic              r_ready;
    logic              w_clr, w_en, w_last_tap, w_last_px, w_row_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)  w_next = LOAD;
            LOAD:    if (w_last_tap) w_next = WRITE;
            WRITE:   w_next = w_last_px ? DONE : LOAD;
            DONE:    if (!bus.start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_row_end  = (r_ox == ADDR_W'(IMG_W - 3));
        w_last_px  = w_row_end && (r_oy == ADDR_W'(IMG_H - 3));
        w_last_tap = (r_state == LOAD) && (r_tap == 4'd8);
        w_en       = (r_state == LOAD);
        w_clr      = ((r_state == IDLE) && bus.start) || (r_state == WRITE);
    end

    // r_base tracks the top-left input address of the current window, so row
    // wraps and tap steps are plain additions rather than multiplies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tap     <= '0;
            r_kx      <= '0;
            r_ox      <= '0;
            r_oy      <= '0;
            r_base    <= '0;
            r_addr_rd <= '0;
            r_addr_wr <= '0;
            r_dout    <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_tap     <= '0;
                    r_kx      <= '0;
                    r_ox      <= '0;
                    r_oy      <= '0;
                    r_base    <= '0;
                    r_addr_rd <= '0;
                end
                LOAD: if (w_last_tap) begin
                    r_dout    <= w_result;
                    r_addr_wr <= ADDR_W'(r_oy * ADDR_W'(IMG_W - 2) + r_ox);
                    r_ready   <= 1'b1;
                end else begin
                    r_tap <= r_tap + 4'd1;
                    if (r_kx == 2'd2) begin
                        r_kx      <= '0;
                        r_addr_rd <= r_addr_rd + ADDR_W'(IMG_W - 2);
                    end else begin
                        r_kx      <= r_kx + 2'd1;
                        r_addr_rd <= r_addr_rd + ADDR_W'(1);
                    end
                end
                WRITE: begin
                    r_ready <= 1'b0;
                    r_tap   <= '0;
                    r_kx    <= '0;
                    if (!w_last_px) begin
                        if (w_row_end) begin
                            r_ox      <= '0;
                            r_oy      <= r_oy + ADDR_W'(1);
                            r_base    <= r_base + ADDR_W'(3);
                            r_addr_rd <= r_base + ADDR_W'(3);
                        end else begin
                            r_ox      <= r_ox + ADDR_W'(1);
                            r_base    <= r_base + ADDR_W'(1);
                            r_addr_rd <= r_base + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    conv2d_mac #(
        .WEIGHTS (WEIGHTS),
        .SHIFT   (SHIFT)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .i_tap    (r_tap),
        .i_pix    (bus.d_in),
        .o_result (w_result)
    );

    assign bus.addr_rd = r_addr_rd;
    assign bus.addr_wr = r_addr_wr;
    assign bus.d_out   = r_dout;
    assign bus.ready   = r_ready;
endmodule

// File: tb/tb_conv2d.sv
// Bench for conv2d: three instances (default kernel, box kernel, unshifted
// default kernel) fed from bench-side image arrays and checked per strobe.
module tb_conv2d;
    localparam int NPIX = 25;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv2d_if ifA ();
    conv2d_if ifB ();
    conv2d_if ifC ();

    logic [11:0] imgA [NPIX];
    logic [11:0] imgB [NPIX];
    logic [11:0] imgC [NPIX];

    assign ifA.d_in = (ifA.addr_rd < 17'd25) ? imgA[ifA.addr_rd[4:0]] : 12'd0;
    assign ifB.d_in = (ifB.addr_rd < 17'd25) ? imgB[ifB.addr_rd[4:0]] : 12'd0;
    assign ifC.d_in = (ifC.addr_rd < 17'd25) ? imgC[ifC.addr_rd[4:0]] : 12'd0;

    conv2d #(.IMG_W(5), .IMG_H(5), .SHIFT(4)) u_a (.clk(clk), .rst(rst), .bus(ifA));
    conv2d #(.IMG_W(5), .IMG_H(5), .WEIGHTS(36'h111111111), .SHIFT(0)) u_b (.clk(clk), .rst(rst), .bus(ifB));
    conv2d #(.IMG_W(5), .IMG_H(5), .WEIGHTS(36'h121242121), .SHIFT(0)) u_c (.clk(clk), .rst(rst), .bus(ifC));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_v [9];
    int max_rd   = 0;

    int kern [3][9] = '{'{1, 2, 1, 2, 4, 2, 1, 2, 1},
                        '{1, 1, 1, 1, 1, 1, 1, 1, 1},
                        '{1, 2, 1, 2, 4, 2, 1, 2, 1}};
    int shft [3] = '{4, 0, 0};

    always @(negedge clk) begin
        if (int'(ifA.addr_rd) > max_rd) max_rd <= int'(ifA.addr_rd);
        if (int'(ifB.addr_rd) > max_rd) max_rd <= int'(ifB.addr_rd);
        if (int'(ifC.addr_rd) > max_rd) max_rd <= int'(ifC.addr_rd);
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sel_ready(input int s);
        case (s)
            0:       return int'(ifA.ready);
            1:       return int'(ifB.ready);
            default: return int'(ifC.ready);
        endcase
    endfunction

    function automatic int sel_addr_wr(input int s);
        case (s)
            0:       return int'(ifA.addr_wr);
            1:       return int'(ifB.addr_wr);
            default: return int'(ifC.addr_wr);
        endcase
    endfunction

    function automatic int sel_d_out(input int s);
        case (s)
            0:       return int'(ifA.d_out);
            1:       return int'(ifB.d_out);
            default: return int'(ifC.d_out);
        endcase
    endfunction

    function automatic int pixel(input int s, input int idx);
        case (s)
            0:       return int'(imgA[idx]);
            1:       return int'(imgB[idx]);
            default: return int'(imgC[idx]);
        endcase
    endfunction

    // Reference: direct valid-mode convolution, shift, then clamp to 12 bits.
    task automatic model(input int s);
        for (int oy = 0; oy < 3; oy++)
            for (int ox = 0; ox < 3; ox++) begin
                int acc;
                acc = 0;
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        acc += kern[s][ky*3 + kx] * pixel(s, (oy + ky)*5 + ox + kx);
                acc = acc >> shft[s];
                exp_v[oy*3 + ox] = (acc > 4095) ? 4095 : acc;
            end
    endtask

    // Start must already be high and the DUT in IDLE before the next rising edge.
    task automatic run_frame(input int s, input string tag);
        int got, last, cyc;
        got = 0; last = 0; cyc = 0;
        while (got < 9 && cyc < 150) begin
            @(negedge clk);
            cyc++;
            if (sel_ready(s) != 0) begin
                check({tag, "_addr_wr"}, sel_addr_wr(s), got);
                check({tag, "_d_out"}, sel_d_out(s), exp_v[got]);
                check({tag, "_gap"}, cyc - last, 10);
                last = cyc;
                got++;
            end
        end
        check({tag, "_strobes"}, got, 9);
        got = 0;
        repeat (25) begin
            @(negedge clk);
            if (sel_ready(s) != 0) got++;
        end
        check({tag, "_quiet"}, got, 0);
        check({tag, "_hold_addr_wr"}, sel_addr_wr(s), 8);
        check({tag, "_hold_d_out"}, sel_d_out(s), exp_v[8]);
    endtask

    initial begin
        rst = 1'b0;
        ifA.start = 1'b0;
        ifB.start = 1'b0;
        ifC.start = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            imgA[i] = '0; imgB[i] = '0; imgC[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_ready",   int'(ifA.ready),   0);
        check("reset_addr_rd", int'(ifA.addr_rd), 0);
        check("reset_addr_wr", int'(ifA.addr_wr), 0);
        check("reset_d_out",   int'(ifA.d_out),   0);
        rst = 1'b1;
        @(negedge clk);

        // Constant image, start held high through DONE.
        for (int i = 0; i < NPIX; i++) imgA[i] = 12'd100;
        for (int i = 0; i < 9; i++) exp_v[i] = 100;
        ifA.start = 1'b1;
        run_frame(0, "const");

        // Drop start for one cycle, then rerun on an impulse image.
        ifA.start = 1'b0;
        for (int i = 0; i < NPIX; i++) imgA[i] = '0;
        imgA[12] = 12'd16;
        exp_v = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        @(negedge clk);
        ifA.start = 1'b1;
        run_frame(0, "impulse");

        // Horizontal ramp through the box kernel.
        for (int i = 0; i < NPIX; i++) imgB[i] = 12'(10 * (i % 5));
        exp_v = '{90, 180, 270, 90, 180, 270, 90, 180, 270};
        ifB.start = 1'b1;
        run_frame(1, "ramp");

        // Full-scale image with no shift must clamp.
        for (int i = 0; i < NPIX; i++) imgC[i] = 12'd4095;
        for (int i = 0; i < 9; i++) exp_v[i] = 4095;
        ifC.start = 1'b1;
        run_frame(2, "sat");

        for (int f = 0; f < 3; f++) begin
            ifA.start = 1'b0;
            for (int i = 0; i < NPIX; i++) imgA[i] = 12'($urandom_range(0, 4095));
            model(0);
            @(negedge clk);
            ifA.start = 1'b1;
            run_frame(0, "rand");
        end

        // Abort during the third pixel's LOAD, then restart from the top.
        ifA.start = 1'b0;
        @(negedge clk);
        ifA.start = 1'b1;
        repeat (24) @(negedge clk);
        check("midrun_addr_wr_before", int'(ifA.addr_wr), 1);
        rst = 1'b0;
        #1;
        check("midrun_ready",   int'(ifA.ready),   0);
        check("midrun_addr_rd", int'(ifA.addr_rd), 0);
        check("midrun_addr_wr", int'(ifA.addr_wr), 0);
        check("midrun_d_out",   int'(ifA.d_out),   0);
        @(negedge clk);
        rst = 1'b1;
        model(0);
        run_frame(0, "restart");

        check("addr_rd_max", (max_rd <= 24) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
